// File: rtl/alu_stage_pkg.sv
// Shared constants for the ALU operand/writeback stage.
// Holds the instruction field layout, the hard-wired zero register index and
// the default datapath widths used by alu_operand_stage and reg_file.
package alu_stage_pkg;

    // Default widths; DEF_DW and DEF_OPW must match the downstream ALU
    localparam int unsigned DEF_DW  = 8;
    localparam int unsigned DEF_RN  = 8;
    localparam int unsigned DEF_AW  = 3;
    localparam int unsigned DEF_OPW = 3;
    localparam int unsigned IW      = 16;

    // Instruction layout: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] reserved
    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 13;
    localparam int unsigned RD_HI  = 12;
    localparam int unsigned RD_LO  = 10;
    localparam int unsigned RS1_HI = 9;
    localparam int unsigned RS1_LO = 7;
    localparam int unsigned RS2_HI = 6;
    localparam int unsigned RS2_LO = 4;
    localparam int unsigned RSV_HI = 3;
    localparam int unsigned RSV_LO = 0;

    // r0 always reads zero and ignores writes
    localparam logic [DEF_AW-1:0] ZERO_REG = '0;

    // Decoded instruction payload
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] rsvd;
    } instr_t;

endpackage : alu_stage_pkg

// File: rtl/alu_operand_stage_reg_file.sv
// reg_file: RN x DW register file with two combinational read ports and one
// write port. Register 0 is hard-wired to zero: reads return 0, writes drop.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all registers)
//   we, waddr, wdata    write port, lands at the rising edge
//   raddr1, rdata1_c    read port 1 (combinational)
//   raddr2, rdata2_c    read port 2 (combinational)
module reg_file
    import alu_stage_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned RN = DEF_RN,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1_c,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2_c
);

    logic [DW-1:0] mem [RN];

    // Storage; r0 write suppressed here as a second line of defence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RN); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != AW'(ZERO_REG))) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports
    always_comb begin
        rdata1_c = (raddr1 == AW'(ZERO_REG)) ? '0 : mem[raddr1];
        rdata2_c = (raddr2 == AW'(ZERO_REG)) ? '0 : mem[raddr2];
    end

endmodule : reg_file

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: issue/writeback stage in front of the 8-bit ALU.
// Accepts reg-reg instructions over valid/ready, reads operands (with EX
// forwarding), drives registered ALU operands/select, and one cycle later
// captures the ALU result and zero flag and writes the result back.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr, instr_valid         instruction and its valid
//   instr_ready                combinational: low while ld_en is asserted
//   ld_en, ld_addr, ld_data    external register load
//   alu_in1, alu_in2, alu_sel  registered ALU operands and op select
//   alu_out, alu_z             ALU result and zero flag (combinational ALU)
//   res_valid, res_data, res_rd  one-cycle writeback report
//   z_flag                     zero flag of the last completed instruction
module alu_operand_stage
    import alu_stage_pkg::*;
#(
    parameter  int unsigned DW  = DEF_DW,
    parameter  int unsigned RN  = DEF_RN,
    parameter  int unsigned OPW = DEF_OPW,
    localparam int unsigned AW  = $clog2(RN)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IW-1:0]  instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic           ld_en,
    input  logic [AW-1:0]  ld_addr,
    input  logic [DW-1:0]  ld_data,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    output logic [OPW-1:0] alu_sel,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_z,
    output logic           res_valid,
    output logic [DW-1:0]  res_data,
    output logic [AW-1:0]  res_rd,
    output logic           z_flag
);

    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    // Decoded instruction fields
    logic [OPW-1:0] dec_op;
    logic [AW-1:0]  dec_rd;
    logic [AW-1:0]  dec_rs1;
    logic [AW-1:0]  dec_rs2;
    logic           unused_rsvd;

    assign dec_op      = OPW'(instr[OP_HI:OP_LO]);
    assign dec_rd      = AW'(instr[RD_HI:RD_LO]);
    assign dec_rs1     = AW'(instr[RS1_HI:RS1_LO]);
    assign dec_rs2     = AW'(instr[RS2_HI:RS2_LO]);
    assign unused_rsvd = ^instr[RSV_HI:RSV_LO];

    // EX stage state
    logic          ex_valid;
    logic [AW-1:0] ex_rd;

    // Deferred EX writeback: when an ld and an EX writeback target different
    // registers in the same cycle, the ld takes the single write port and the
    // EX result is parked here and drained on the next non-ld cycle.
    logic          pend_valid;
    logic [AW-1:0] pend_rd;
    logic [DW-1:0] pend_data;

    logic          issue;
    logic          ld_wr;
    logic          ex_wr;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata1;
    logic [DW-1:0] rf_rdata2;
    logic          pend_set;
    logic          pend_clr;
    logic [DW-1:0] opnd1_c;
    logic [DW-1:0] opnd2_c;

    assign instr_ready = !ld_en;
    assign issue       = instr_valid && instr_ready;
    assign ld_wr       = ld_en && (ld_addr != R0);
    assign ex_wr       = ex_valid && (ex_rd != R0);

    reg_file #(
        .DW (DW),
        .RN (RN),
        .AW (AW)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (dec_rs1),
        .rdata1_c (rf_rdata1),
        .raddr2   (dec_rs2),
        .rdata2_c (rf_rdata2)
    );

    // Operand select: r0, then EX forward, then parked writeback, then regfile.
    // A parked writeback and a valid EX stage never coexist: parking only
    // happens on an ld cycle, which blocks issue.
    function automatic logic [DW-1:0] pick_operand(
        input logic [AW-1:0] rs,
        input logic [DW-1:0] rf_val,
        input logic          fwd_ex,
        input logic [AW-1:0] fwd_ex_rd,
        input logic [DW-1:0] fwd_ex_data,
        input logic          fwd_pd,
        input logic [AW-1:0] fwd_pd_rd,
        input logic [DW-1:0] fwd_pd_data
    );
        logic [DW-1:0] val;
        val = rf_val;
        if (rs == R0) begin
            val = '0;
        end else if (fwd_ex && (fwd_ex_rd == rs)) begin
            val = fwd_ex_data;
        end else if (fwd_pd && (fwd_pd_rd == rs)) begin
            val = fwd_pd_data;
        end
        return val;
    endfunction

    always_comb begin
        opnd1_c = pick_operand(dec_rs1, rf_rdata1, ex_valid, ex_rd, alu_out,
                               pend_valid, pend_rd, pend_data);
        opnd2_c = pick_operand(dec_rs2, rf_rdata2, ex_valid, ex_rd, alu_out,
                               pend_valid, pend_rd, pend_data);
    end

    // Write-port arbitration: ld wins; parked result drains before new EX data
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        pend_set = 1'b0;
        pend_clr = 1'b0;
        if (ld_wr) begin
            rf_we    = 1'b1;
            rf_waddr = ld_addr;
            rf_wdata = ld_data;
            if (ex_wr && (ex_rd != ld_addr)) begin
                pend_set = 1'b1;
            end else if (pend_valid && (pend_rd == ld_addr)) begin
                // Newer ld supersedes the parked value for the same register
                pend_clr = 1'b1;
            end
        end else if (pend_valid) begin
            rf_we    = 1'b1;
            rf_waddr = pend_rd;
            rf_wdata = pend_data;
            pend_clr = 1'b1;
        end else if (ex_wr) begin
            rf_we    = 1'b1;
            rf_waddr = ex_rd;
            rf_wdata = alu_out;
        end
    end

    // Parked writeback register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            pend_data  <= '0;
        end else if (pend_set) begin
            pend_valid <= 1'b1;
            pend_rd    <= ex_rd;
            pend_data  <= alu_out;
        end else if (pend_clr) begin
            pend_valid <= 1'b0;
        end
    end

    // Issue: register operands and op; operands hold when nothing issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_rd    <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_sel  <= '0;
        end else begin
            ex_valid <= issue;
            if (issue) begin
                ex_rd   <= dec_rd;
                alu_in1 <= opnd1_c;
                alu_in2 <= opnd2_c;
                alu_sel <= dec_op;
            end
        end
    end

    // Writeback report; rd==0 still reports and updates the zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            z_flag    <= 1'b0;
        end else begin
            res_valid <= ex_valid;
            if (ex_valid) begin
                res_data <= alu_out;
                res_rd   <= ex_rd;
                z_flag   <= alu_z;
            end
        end
    end

endmodule : alu_operand_stage
